dshot_tx: RTL and testbench

Serial DShot encoder. It takes an 11-bit throttle word plus a telemetry-request bit, appends the 4-bit DShot CRC, and drives one 16-bit pulse-width frame onto an ESC signal pin. It is the transmit counterpart of the DShot speed receiver: the converter re-emits decoded or computed motor commands as DShot toward downstream ESCs. It runs on the board's 16 MHz clock and sits beside the PWM and BLCtrl output paths in `top`.

---
 rtl/dshot_pkg.sv | 44 ++++
 rtl/dshot_if.sv | 28 ++
 rtl/dshot_tx.sv | 133 +++++++++++++
 tb/tb_dshot_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dshot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dshot_pkg
// Brief    : Shared DShot constants, state encoding, CRC and default timings.
// Revision : 1.0 - initial release
// ============================================================================
package dshot_pkg;

    localparam int DSHOT_FRAME_BITS = 16;
    localparam int DSHOT_VALUE_BITS = 11;
    localparam int DSHOT_CRC_BITS   = 4;

    typedef enum logic [1:0] {
        DSHOT_ST_IDLE = 2'd0,
        DSHOT_ST_HIGH = 2'd1,
        DSHOT_ST_LOW  = 2'd2,
        DSHOT_ST_GAP  = 2'd3
    } dshot_state_e;

    // Nibble-wise XOR over {throttle, telem}
    function automatic logic [DSHOT_CRC_BITS-1:0] dshot_crc(input logic [11:0] v);
        logic [11:0] w_x;
        w_x = v ^ (v >> 4) ^ (v >> 8);
        return w_x[DSHOT_CRC_BITS-1:0];
    endfunction

    // Default timings at 16 MHz
    localparam int DSHOT150_BIT_CYCLES = 107;
    localparam int DSHOT150_T1H_CYCLES = 80;
    localparam int DSHOT150_T0H_CYCLES = 40;
    localparam int DSHOT150_GAP_CYCLES = 320;

    localparam int DSHOT300_BIT_CYCLES = 53;
    localparam int DSHOT300_T1H_CYCLES = 40;
    localparam int DSHOT300_T0H_CYCLES = 20;
    localparam int DSHOT300_GAP_CYCLES = 160;

    localparam int DSHOT600_BIT_CYCLES = 27;
    localparam int DSHOT600_T1H_CYCLES = 20;
    localparam int DSHOT600_T0H_CYCLES = 10;
    localparam int DSHOT600_GAP_CYCLES = 80;

endpackage
`default_nettype wire

// File: rtl/dshot_if.sv
`default_nettype none
// ============================================================================
// Module   : dshot_if
// Brief    : Frame-request handshake between a command source and dshot_tx.
// Revision : 1.0 - initial release
// ============================================================================
interface dshot_if;
    import dshot_pkg::*;

    logic                        valid;
    logic [DSHOT_VALUE_BITS-1:0] throttle;
    logic                        telem;
    logic                        ready;
    logic                        busy;
    logic                        frame_done;

    modport master (
        output valid, throttle, telem,
        input  ready, busy, frame_done
    );

    modport slave (
        input  valid, throttle, telem,
        output ready, busy, frame_done
    );

endinterface
`default_nettype wire

// File: rtl/dshot_tx.sv
`default_nettype none
// ============================================================================
// Module   : dshot_tx
// Brief    : DShot frame encoder: latches throttle/telem, appends CRC and
//            drives a 16-bit MSB-first pulse-width frame followed by a gap.
// Revision : 1.0 - initial release
// ============================================================================
module dshot_tx
    import dshot_pkg::*;
#(
    parameter int BIT_CYCLES = DSHOT150_BIT_CYCLES,
    parameter int T1H_CYCLES = DSHOT150_T1H_CYCLES,
    parameter int T0H_CYCLES = DSHOT150_T0H_CYCLES,
    parameter int GAP_CYCLES = DSHOT150_GAP_CYCLES
) (
    input  wire logic clk,
    input  wire logic rst_n,
    dshot_if.slave    bus,
    output logic      dshot_out
);

    localparam int c_cnt_max = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam int c_idx_w   = $clog2(DSHOT_FRAME_BITS);

    localparam logic [c_cnt_w-1:0] c_bit_m1 = c_cnt_w'(BIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_t1h_m1 = c_cnt_w'(T1H_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_t0h_m1 = c_cnt_w'(T0H_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_gap_m1 = c_cnt_w'(GAP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_last_bit = c_idx_w'(DSHOT_FRAME_BITS - 1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

    localparam logic [1:0] c_st_idle = DSHOT_ST_IDLE;
    localparam logic [1:0] c_st_high = DSHOT_ST_HIGH;
    localparam logic [1:0] c_st_low  = DSHOT_ST_LOW;
    localparam logic [1:0] c_st_gap  = DSHOT_ST_GAP;

    logic [1:0]                  r_state;
    logic [DSHOT_FRAME_BITS-1:0] r_shift;
    logic [c_idx_w-1:0]          r_idx;
    logic [c_cnt_w-1:0]          r_cnt;
    logic                        r_dshot_out;
    logic                        r_ready;
    logic                        r_busy;
    logic                        r_frame_done;

    logic [DSHOT_VALUE_BITS:0]   w_word;
    logic [DSHOT_FRAME_BITS-1:0] w_frame;
    logic [c_cnt_w-1:0]          w_th_m1;
    logic                        w_accept;

    assign w_word   = {bus.throttle, bus.telem};
    assign w_frame  = {w_word, dshot_crc(w_word)};
    assign w_accept = bus.valid && r_ready;
    // High time is chosen by the bit currently at the top of the shifter
    assign w_th_m1  = r_shift[DSHOT_FRAME_BITS-1] ? c_t1h_m1 : c_t0h_m1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_shift      <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_dshot_out  <= 1'b0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_shift     <= w_frame;
                        r_idx       <= '0;
                        r_cnt       <= '0;
                        r_dshot_out <= 1'b1;
                        r_ready     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= c_st_high;
                    end
                end
                c_st_high: begin
                    // Counter spans the whole bit, so it keeps running into LOW
                    r_cnt <= r_cnt + c_cnt_one;
                    if (r_cnt == w_th_m1) begin
                        r_dshot_out <= 1'b0;
                        r_state     <= c_st_low;
                    end
                end
                c_st_low: begin
                    if (r_cnt == c_bit_m1) begin
                        r_cnt <= '0;
                        if (r_idx != c_last_bit) begin
                            r_shift     <= {r_shift[DSHOT_FRAME_BITS-2:0], 1'b0};
                            r_idx       <= r_idx + c_idx_one;
                            r_dshot_out <= 1'b1;
                            r_state     <= c_st_high;
                        end else begin
                            r_state <= c_st_gap;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                c_st_gap: begin
                    if (r_cnt == c_gap_m1) begin
                        r_cnt        <= '0;
                        r_ready      <= 1'b1;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_state      <= c_st_idle;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_dshot_out <= 1'b0;
                    r_ready     <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= c_st_idle;
                end
            endcase
        end
    end

    assign dshot_out      = r_dshot_out;
    assign bus.ready      = r_ready;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_dshot_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_dshot_tx
// Brief    : Self-checking bench for dshot_tx (DShot150 default and DShot600).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dshot_tx;
    import dshot_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic out_a, out_b;
    logic sel = 1'b0;
    logic cur_valid = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    dshot_if if_a();
    dshot_if if_b();

    dshot_tx u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (if_a),
        .dshot_out (out_a)
    );

    dshot_tx #(
        .BIT_CYCLES (DSHOT600_BIT_CYCLES),
        .T1H_CYCLES (DSHOT600_T1H_CYCLES),
        .T0H_CYCLES (DSHOT600_T0H_CYCLES),
        .GAP_CYCLES (DSHOT600_GAP_CYCLES)
    ) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (if_b),
        .dshot_out (out_b)
    );

    logic w_out, w_ready, w_busy, w_done;
    assign w_out   = sel ? out_b          : out_a;
    assign w_ready = sel ? if_b.ready      : if_a.ready;
    assign w_busy  = sel ? if_b.busy       : if_a.busy;
    assign w_done  = sel ? if_b.frame_done : if_a.frame_done;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5000000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference frame from the DShot rules, with plain integer arithmetic
    function automatic logic [15:0] model_frame(input int thr, input int tel);
        int v, c;
        v = thr * 2 + tel;
        c = (v ^ (v >> 4) ^ (v >> 8)) % 16;
        return 16'(v * 16 + c);
    endfunction

    task automatic set_valid(input logic v);
        cur_valid = v;
        if (sel) if_b.valid = v; else if_a.valid = v;
    endtask

    task automatic set_thr(input int thr);
        if (sel) if_b.throttle = 11'(thr); else if_a.throttle = 11'(thr);
    endtask

    task automatic start(input int thr, input int tel);
        int g = 0;
        while (w_ready !== 1'b1 && g < 3000) begin @(negedge clk); g++; end
        set_thr(thr);
        if (sel) if_b.telem = tel[0]; else if_a.telem = tel[0];
        set_valid(1'b1);
    endtask

    task automatic wait_rise(output bit ok);
        int g = 0;
        while (w_out !== 1'b1 && g < 3000) begin @(negedge clk); g++; end
        ok = (w_out === 1'b1);
    endtask

    // Observe one frame from its first rising edge to the end of its gap
    task automatic capture(input string tag, input int bc, input int t1, input int t0,
                           input int gc, input logic [15:0] expw, input bit hold,
                           input bit disturb, input int new_thr, output int start_cyc);
        int npulse = 0, start_err = 0, width_err = 0, done_cnt = 0;
        int done_at = -1, ready_at = -1, busy_err = 0, width = 0, last;
        logic prev = 1'b0, o, b;
        logic [15:0] dec = '0;
        bit ok;
        wait_rise(ok);
        chk({tag, " accept"}, 32'(ok), 32'd1);
        start_cyc = cyc;
        if (!ok) return;
        if (!hold) set_valid(1'b0);
        last = 16 * bc + gc;
        for (int t = 0; t <= last; t++) begin
            if (t > 0) @(negedge clk);
            o = w_out;
            if (hold && t == 1) set_thr(new_thr);
            if (disturb && t < last - 5 && (t % 97) == 50) begin
                set_valid(~cur_valid);
                set_thr($urandom_range(2047, 0));
            end
            if (disturb && t == last - 5) set_valid(1'b0);
            if (o === 1'b1 && prev === 1'b0) begin
                if (t != npulse * bc) start_err++;
                npulse++;
                width = 0;
            end
            if (o === 1'b1) width++;
            if (o === 1'b0 && prev === 1'b1) begin
                b = (2 * width > t1 + t0);
                if (npulse >= 1 && npulse <= 16) dec[16 - npulse] = b;
                if (width != (b ? t1 : t0)) width_err++;
            end
            if (o !== 1'b0 && o !== 1'b1) width_err++;
            if (w_done === 1'b1) begin done_cnt++; done_at = t; end
            if (w_ready === 1'b1 && ready_at < 0) ready_at = t;
            if (w_busy !== ~w_ready) busy_err++;
            prev = o;
        end
        chk({tag, " pulses"},    32'(npulse),    32'd16);
        chk({tag, " word"},      32'(dec),       32'(expw));
        chk({tag, " bit_start"}, 32'(start_err), 32'd0);
        chk({tag, " high_time"}, 32'(width_err), 32'd0);
        chk({tag, " ready_at"},  32'(ready_at),  32'(last));
        chk({tag, " done_cnt"},  32'(done_cnt),  32'd1);
        chk({tag, " done_at"},   32'(done_at),   32'(last));
        chk({tag, " busy_inv"},  32'(busy_err),  32'd0);
    endtask

    initial begin
        int c1, c2, r1, r2, tl, viol;
        if_a.valid = 1'b0; if_a.throttle = '0; if_a.telem = 1'b0;
        if_b.valid = 1'b0; if_b.throttle = '0; if_b.telem = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst ready_a", 32'(if_a.ready), 32'd1);
        chk("rst busy_a",  32'(if_a.busy), 32'd0);
        chk("rst done_a",  32'(if_a.frame_done), 32'd0);
        chk("rst out_a",   32'(out_a), 32'd0);
        chk("rst ready_b", 32'(if_b.ready), 32'd1);
        chk("rst out_b",   32'(out_b), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed encodings and boundary values on DShot150
        start(1046, 0);
        capture("f1046", 107, 80, 40, 320, 16'h82C6, 1'b0, 1'b0, 0, c1);
        start(0, 0);
        capture("f0", 107, 80, 40, 320, 16'h0000, 1'b0, 1'b0, 0, c1);
        start(2047, 1);
        capture("f2047", 107, 80, 40, 320, 16'hFFFF, 1'b0, 1'b0, 0, c1);

        // Back-to-back with valid held; throttle changes mid-frame
        r2 = $urandom_range(2047, 0);
        start(48, 1);
        capture("b2b_1", 107, 80, 40, 320, 16'h0617, 1'b1, 1'b0, r2, c1);
        capture("b2b_2", 107, 80, 40, 320, model_frame(r2, 1), 1'b0, 1'b0, 0, c2);
        chk("b2b period", 32'(c2 - c1), 32'd2033);

        // Input disturbance during a frame
        r1 = $urandom_range(2047, 0); tl = $urandom_range(1, 0);
        start(r1, tl);
        capture("disturb", 107, 80, 40, 320, model_frame(r1, tl), 1'b0, 1'b1, 0, c1);
        viol = 0;
        repeat (40) begin
            @(negedge clk);
            if (w_out !== 1'b0 || w_ready !== 1'b1) viol++;
        end
        chk("no_extra_accept", 32'(viol), 32'd0);

        // Random frames
        for (int i = 0; i < 3; i++) begin
            r1 = $urandom_range(2047, 0); tl = $urandom_range(1, 0);
            start(r1, tl);
            capture("rand", 107, 80, 40, 320, model_frame(r1, tl), 1'b0, 1'b0, 0, c1);
        end

        // Reset during bit 7
        r1 = $urandom_range(2047, 0); tl = $urandom_range(1, 0);
        start(r1, tl);
        begin
            bit ok;
            wait_rise(ok);
            chk("rst_mid accept", 32'(ok), 32'd1);
        end
        set_valid(1'b0);
        repeat (7 * 107 + 3) @(negedge clk);
        chk("rst_mid pre_high", 32'(out_a), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid out_async", 32'(out_a), 32'd0);
        chk("rst_mid ready_async", 32'(if_a.ready), 32'd1);
        chk("rst_mid busy_async", 32'(if_a.busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_a !== 1'b0 || if_a.ready !== 1'b1) viol++;
        end
        chk("rst_mid no_resume", 32'(viol), 32'd0);
        r1 = $urandom_range(2047, 0); tl = $urandom_range(1, 0);
        start(r1, tl);
        capture("post_rst", 107, 80, 40, 320, model_frame(r1, tl), 1'b0, 1'b0, 0, c1);

        // DShot600 parameter override
        sel = 1'b1;
        @(negedge clk);
        r1 = $urandom_range(2047, 0); r2 = $urandom_range(2047, 0); tl = $urandom_range(1, 0);
        start(r1, tl);
        capture("d600_1", 27, 20, 10, 80, model_frame(r1, tl), 1'b1, 1'b0, r2, c1);
        capture("d600_2", 27, 20, 10, 80, model_frame(r2, tl), 1'b0, 1'b0, 0, c2);
        chk("d600 period", 32'(c2 - c1), 32'd513);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
